// File: rtl/musa_trace_buffer.sv
// rtl/musa_trace_buffer.sv - circular trace capture buffer with masked-compare trigger and post-trigger stop
module musa_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 64,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int TCH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] probe_i,
  input  logic                         sample_en_i,
  input  logic                         arm_i,
  input  logic                         abort_i,
  input  logic [TCH_W-1:0]             trig_ch_i,
  input  logic [DATA_WIDTH-1:0]        trig_value_i,
  input  logic [DATA_WIDTH-1:0]        trig_mask_i,
  input  logic [ADDR_W-1:0]            post_count_i,
  input  logic                         rd_req_i,
  input  logic [ADDR_W-1:0]            rd_idx_i,
  output logic                         rd_valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data_o,
  output logic [1:0]                   state_o,
  output logic                         done_o,
  output logic [ADDR_W:0]              entry_count_o,
  output logic [ADDR_W-1:0]            trig_index_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [NUM_CH*DATA_WIDTH-1:0] mem [DEPTH];

  state_t            state, state_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W:0]   total, total_next;
  logic [ADDR_W-1:0] remaining, remaining_next;
  logic [ADDR_W-1:0] trig_ptr, trig_ptr_next;
  logic              wr_en;

  logic [DATA_WIDTH-1:0] trig_word;
  logic                  trig_ch_ok;
  logic                  trig_hit;

  logic [ADDR_W-1:0] start, start_next;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;

  // Select the trigger channel; an index beyond the last channel never matches
  always_comb begin
    trig_word  = '0;
    trig_ch_ok = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(trig_ch_i) == k) begin
        trig_word  = probe_i[k*DATA_WIDTH +: DATA_WIDTH];
        trig_ch_ok = 1'b1;
      end
    end
  end

  assign trig_hit = trig_ch_ok &&
                    ((trig_word & trig_mask_i) == (trig_value_i & trig_mask_i));

  // Next-state and capture bookkeeping; abort beats arm beats sampling
  always_comb begin
    state_next     = state;
    wr_ptr_next    = wr_ptr;
    total_next     = total;
    remaining_next = remaining;
    trig_ptr_next  = trig_ptr;
    wr_en          = 1'b0;
    if (abort_i) begin
      state_next = S_IDLE;
    end else if (arm_i) begin
      state_next  = S_ARMED;
      wr_ptr_next = '0;
      total_next  = '0;
    end else if (sample_en_i && (state == S_ARMED || state == S_POST)) begin
      wr_en       = 1'b1;
      wr_ptr_next = wr_ptr + 1'b1;
      if (total != FULL) begin
        total_next = total + 1'b1;
      end
      if (state == S_ARMED) begin
        if (trig_hit) begin
          // The ADDR_W-wide post count already tops out at DEPTH-1
          trig_ptr_next  = wr_ptr;
          remaining_next = post_count_i;
          state_next     = (post_count_i == '0) ? S_DONE : S_POST;
        end
      end else begin
        remaining_next = remaining - 1'b1;
        if (remaining == ADDR_W'(1)) begin
          state_next = S_DONE;
        end
      end
    end
  end

  // Oldest entry sits at the write pointer once the buffer has wrapped
  always_comb begin
    start       = (total == FULL) ? wr_ptr : '0;
    start_next  = (total_next == FULL) ? wr_ptr_next : '0;
    rd_addr     = start + rd_idx_i;
    rd_in_range = ({1'b0, rd_idx_i} < total);
  end

  // Control state, pointers and the registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      total         <= '0;
      remaining     <= '0;
      trig_ptr      <= '0;
      done_o        <= 1'b0;
      entry_count_o <= '0;
      trig_index_o  <= '0;
    end else begin
      state     <= state_next;
      wr_ptr    <= wr_ptr_next;
      total     <= total_next;
      remaining <= remaining_next;
      trig_ptr  <= trig_ptr_next;
      done_o    <= (state_next == S_DONE);
      if (state_next == S_DONE) begin
        entry_count_o <= total_next;
        trig_index_o  <= trig_ptr_next - start_next;
      end else begin
        entry_count_o <= '0;
        trig_index_o  <= '0;
      end
    end
  end

  // Sample storage; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr] <= probe_i;
    end
  end

  // One-cycle read port, serviced only while the capture is complete
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else if (rd_req_i && state == S_DONE) begin
      rd_valid_o <= 1'b1;
      rd_data_o  <= rd_in_range ? mem[rd_addr] : '0;
    end else begin
      rd_valid_o <= 1'b0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_musa_trace_buffer.sv
// tb/tb_musa_trace_buffer.sv - self-checking bench for musa_trace_buffer
module tb_musa_trace_buffer;

  logic        clk;
  logic        rst_n;
  logic [15:0] probe;
  logic        sample_en;
  logic        arm;
  logic        abort;
  logic [0:0]  trig_ch;
  logic [7:0]  trig_value;
  logic [7:0]  trig_mask;
  logic [2:0]  post_count;
  logic        rd_req;
  logic [2:0]  rd_idx;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [1:0]  state;
  logic        done;
  logic [3:0]  entry_count;
  logic [2:0]  trig_index;

  int checks   = 0;
  int failures = 0;

  musa_trace_buffer #(.DATA_WIDTH(8), .NUM_CH(2), .DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .probe_i      (probe),
    .sample_en_i  (sample_en),
    .arm_i        (arm),
    .abort_i      (abort),
    .trig_ch_i    (trig_ch),
    .trig_value_i (trig_value),
    .trig_mask_i  (trig_mask),
    .post_count_i (post_count),
    .rd_req_i     (rd_req),
    .rd_idx_i     (rd_idx),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data),
    .state_o      (state),
    .done_o       (done),
    .entry_count_o(entry_count),
    .trig_index_o (trig_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the captured window is simply the last DEPTH samples since arm
  int          m_state;
  logic [15:0] hist[$];
  int          n_wr;
  int          m_trig_abs;
  int          m_rem;
  logic        m_rdv;
  logic [15:0] m_rdd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] w;
    if (!rst_n) begin
      m_state = 0; hist.delete(); n_wr = 0; m_rdv = 1'b0; m_rdd = '0;
      return;
    end
    if (rd_req && m_state == 3) begin
      m_rdv = 1'b1;
      m_rdd = (int'(rd_idx) < hist.size()) ? hist[rd_idx] : 16'h0000;
    end else begin
      m_rdv = 1'b0;
    end
    if (abort) begin
      m_state = 0;
    end else if (arm) begin
      m_state = 1; hist.delete(); n_wr = 0;
    end else if (sample_en && (m_state == 1 || m_state == 2)) begin
      hist.push_back(probe);
      n_wr++;
      if (hist.size() > 8) void'(hist.pop_front());
      if (m_state == 1) begin
        w = trig_ch ? probe[15:8] : probe[7:0];
        if ((w & trig_mask) == (trig_value & trig_mask)) begin
          m_trig_abs = n_wr - 1;
          m_rem      = int'(post_count);
          m_state    = (post_count == 0) ? 3 : 2;
        end
      end else begin
        m_rem--;
        if (m_rem == 0) m_state = 3;
      end
    end
  endtask

  task automatic check_model();
    int ec, et;
    ec = (m_state == 3) ? hist.size() : 0;
    et = (m_state == 3) ? (m_trig_abs - (n_wr - hist.size())) : 0;
    chk("model_state", state, m_state);
    chk("model_done", done, (m_state == 3));
    chk("model_entry_count", entry_count, ec);
    chk("model_trig_index", trig_index, et);
    chk("model_rd_valid", rd_valid, m_rdv);
    chk("model_rd_data", rd_data, m_rdd);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive(input logic a, input logic ab, input logic s, input logic [7:0] v,
                       input logic r, input logic [2:0] i);
    arm = a; abort = ab; sample_en = s; probe = {8'h50 + v, v}; rd_req = r; rd_idx = i;
    cycle();
  endtask

  task automatic set_trig(input logic c, input logic [7:0] v, input logic [7:0] m, input logic [2:0] p);
    trig_ch = c; trig_value = v; trig_mask = m; post_count = p;
  endtask

  typedef struct packed {
    logic        arm;
    logic        smp;
    logic [7:0]  val;
    logic        rd;
    logic [2:0]  idx;
    logic [1:0]  e_state;
    logic [3:0]  e_cnt;
    logic [2:0]  e_tidx;
    logic        e_rdv;
    logic        chk_d;
    logic [15:0] e_rdd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic a, input logic s, input logic [7:0] v, input logic r, input logic [2:0] i,
                     input logic [1:0] st, input logic [3:0] c, input logic [2:0] t,
                     input logic rv, input logic cd, input logic [15:0] d);
    vec_t x;
    x.arm = a; x.smp = s; x.val = v; x.rd = r; x.idx = i;
    x.e_state = st; x.e_cnt = c; x.e_tidx = t; x.e_rdv = rv; x.chk_d = cd; x.e_rdd = d;
    tbl.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; probe = '0; sample_en = 0; arm = 0; abort = 0;
    rd_req = 0; rd_idx = '0;
    set_trig(1'b0, 8'h00, 8'hFF, 3'd0);
    cycle(); cycle();
    chk("reset_state", state, 2'd0);
    chk("reset_done", done, 1'b0);
    chk("reset_entry_count", entry_count, 4'd0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_data", rd_data, 16'h0000);
    rst_n = 1'b1;

    // Pre-wrap trigger: value 3, post 2
    set_trig(1'b0, 8'h03, 8'hFF, 3'd2);
    add(1,0,0,0,0, 2'd1,0,0,0,0,16'h0);
    add(0,1,1,0,0, 2'd1,0,0,0,0,16'h0);
    add(0,1,2,0,0, 2'd1,0,0,0,0,16'h0);
    add(0,1,3,0,0, 2'd2,0,0,0,0,16'h0);
    add(0,1,4,0,0, 2'd2,0,0,0,0,16'h0);
    add(0,1,5,0,0, 2'd3,5,2,0,0,16'h0);
    add(0,1,6,0,0, 2'd3,5,2,0,0,16'h0);
    add(0,0,0,1,0, 2'd3,5,2,1,1,16'h5101);
    add(0,0,0,1,1, 2'd3,5,2,1,1,16'h5202);
    add(0,0,0,1,2, 2'd3,5,2,1,1,16'h5303);
    add(0,0,0,1,3, 2'd3,5,2,1,1,16'h5404);
    add(0,0,0,1,4, 2'd3,5,2,1,1,16'h5505);
    add(0,0,0,1,6, 2'd3,5,2,1,1,16'h0000);
    add(0,0,0,1,5, 2'd3,5,2,1,1,16'h0000);
    add(0,0,0,1,2, 2'd3,5,2,1,1,16'h5303);
    add(0,0,0,0,0, 2'd3,5,2,0,1,16'h5303);
    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].arm, 1'b0, tbl[n].smp, tbl[n].val, tbl[n].rd, tbl[n].idx);
      chk($sformatf("tbl%0d_state", n), state, tbl[n].e_state);
      chk($sformatf("tbl%0d_cnt", n), entry_count, tbl[n].e_cnt);
      chk($sformatf("tbl%0d_tidx", n), trig_index, tbl[n].e_tidx);
      chk($sformatf("tbl%0d_rdv", n), rd_valid, tbl[n].e_rdv);
      if (tbl[n].chk_d) chk($sformatf("tbl%0d_rdd", n), rd_data, tbl[n].e_rdd);
    end

    // Wrapped buffer: trigger 0x0F, post 2, samples 1..20
    set_trig(1'b0, 8'h0F, 8'hFF, 3'd2);
    drive(1,0,0,0,0,0);
    for (int n = 1; n <= 20; n++) begin
      drive(0,0,1,8'(n),0,0);
      if (n == 16) chk("wrap_post_at16", state, 2'd2);
      if (n == 17) chk("wrap_done_at17", state, 2'd3);
    end
    chk("wrap_cnt", entry_count, 4'd8);
    chk("wrap_tidx", trig_index, 3'd5);
    for (int i = 0; i < 8; i++) begin
      drive(0,0,0,0,1,3'(i));
      chk($sformatf("wrap_rd%0d", i), rd_data[7:0], 8'(10 + i));
    end

    // Immediate trigger: mask 0, post 0
    set_trig(1'b0, 8'h00, 8'h00, 3'd0);
    drive(1,0,0,0,0,0);
    drive(0,0,1,8'h42,0,0);
    chk("imm_state", state, 2'd3);
    chk("imm_cnt", entry_count, 4'd1);
    chk("imm_tidx", trig_index, 3'd0);
    drive(0,0,0,0,1,0);
    chk("imm_rd0", rd_data[7:0], 8'h42);

    // Maximum post count with sample gaps
    set_trig(1'b0, 8'h01, 8'hFF, 3'd7);
    drive(1,0,0,0,0,0);
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(0,0,1,8'(i/2 + 1),0,0);
      else            drive(0,0,0,8'(8'hC0 + i),0,0);
      if (i == 12) chk("gap_post_at7", state, 2'd2);
      if (i == 14) chk("gap_done_at8", state, 2'd3);
    end
    chk("gap_cnt", entry_count, 4'd8);
    chk("gap_tidx", trig_index, 3'd0);
    for (int i = 0; i < 8; i++) begin
      drive(0,0,0,0,1,3'(i));
      chk($sformatf("gap_rd%0d", i), rd_data[7:0], 8'(i + 1));
    end

    // Arm wins over a triggering sample on the same cycle
    set_trig(1'b0, 8'h33, 8'hFF, 3'd0);
    drive(1,0,0,0,0,0);
    drive(1,0,1,8'h33,0,0);
    chk("prio_arm_state", state, 2'd1);
    drive(0,0,1,8'h11,0,0);
    chk("prio_notrig_state", state, 2'd1);
    drive(0,0,1,8'h33,0,0);
    chk("prio_done", state, 2'd3);
    chk("prio_cnt", entry_count, 4'd2);
    chk("prio_tidx", trig_index, 3'd1);
    drive(0,0,0,0,1,0);
    chk("prio_rd0", rd_data[7:0], 8'h11);
    // Re-arm clears the visible count
    drive(1,0,0,0,0,0);
    chk("rearm_cnt", entry_count, 4'd0);
    chk("rearm_done", done, 1'b0);
    drive(0,0,1,8'h11,0,0);
    chk("rearm_cnt_after_sample", entry_count, 4'd0);
    // Abort during POST, and abort over arm
    set_trig(1'b0, 8'h33, 8'hFF, 3'd3);
    drive(0,0,1,8'h33,0,0);
    chk("abort_pre_post", state, 2'd2);
    drive(0,1,0,0,0,0);
    chk("abort_state", state, 2'd0);
    chk("abort_done", done, 1'b0);
    drive(1,1,0,0,0,0);
    chk("abort_over_arm", state, 2'd0);

    // Reset held for two edges mid-POST
    set_trig(1'b0, 8'h33, 8'hFF, 3'd5);
    drive(1,0,0,0,0,0);
    drive(0,0,1,8'h33,0,0);
    chk("rst_pre_post", state, 2'd2);
    rst_n = 1'b0;
    drive(0,0,1,8'h01,0,0);
    drive(0,0,1,8'h02,0,0);
    chk("rst_state", state, 2'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", entry_count, 4'd0);
    chk("rst_tidx", trig_index, 3'd0);
    chk("rst_rdv", rd_valid, 1'b0);
    chk("rst_rdd", rd_data, 16'h0000);
    rst_n = 1'b1;
    drive(0,0,0,0,1,0);
    chk("rst_rd_req_ignored", rd_valid, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n      = ($urandom_range(0, 499) != 0);
      arm        = ($urandom_range(0, 29) == 0);
      abort      = ($urandom_range(0, 149) == 0);
      sample_en  = ($urandom_range(0, 2) != 0);
      probe      = 16'($urandom);
      rd_req     = $urandom_range(0, 1);
      rd_idx     = 3'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        trig_ch    = 1'($urandom);
        trig_value = 8'($urandom);
        trig_mask  = 8'($urandom) & 8'h07;
        post_count = 3'($urandom);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
